// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 buffered demultiplexer: default sizes,
// channel-select encodings and the width of the optional push counters.
package demux_pkg;
    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_DEPTH = 2;
    localparam logic SEL_A       = 1'b1;
    localparam logic SEL_B       = 1'b0;
    localparam int STATS_W       = 16;
endpackage

// File: rtl/demux_fifo.sv
// Per-channel FIFO, wrap-bit pointers: a push is visible at the head after one edge.
// Backpressure: a push while full and a pop while empty are both ignored.
module demux_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/demux1to2_buffered.sv
// Steers a tagged word stream into two independently drained FIFOs; one-edge latency, no bypass.
// Backpressure: din_ready follows only the selected channel's full flag. Optional DEMUX1TO2_STATS_EN adds push counters.
module demux1to2_buffered
    import demux_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         s,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [W-1:0] b_data,
    output logic         b_valid,
`ifdef DEMUX1TO2_STATS_EN
    input  logic         b_ready,
    output logic [STATS_W-1:0] a_count,
    output logic [STATS_W-1:0] b_count
`else
    input  logic         b_ready
`endif
);
    logic         a_full;
    logic         a_empty;
    logic         b_full;
    logic         b_empty;
    logic [W-1:0] a_head;
    logic [W-1:0] b_head;
    logic         push_a;
    logic         push_b;

    assign din_ready = !rst && ((s == SEL_A) ? !a_full : !b_full);
    assign push_a    = din_valid && din_ready && (s == SEL_A);
    assign push_b    = din_valid && din_ready && (s == SEL_B);

    demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (din),
        .pop   (a_ready),
        .rdata (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (din),
        .pop   (b_ready),
        .rdata (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    // Stale storage must never leak onto an idle channel.
    assign a_valid = !a_empty;
    assign b_valid = !b_empty;
    assign a_data  = a_valid ? a_head : '0;
    assign b_data  = b_valid ? b_head : '0;

`ifdef DEMUX1TO2_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (push_a) a_count <= a_count + STATS_W'(1);
            if (push_b) b_count <= b_count + STATS_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_demux1to2_buffered.sv
// Scoreboard bench: the driver issues directed and random traffic, the negedge monitor
// predicts acceptance from its own queue occupancy and checks every DUT output.
module tb_demux1to2_buffered;
    localparam int W     = 8;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         s;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
`ifdef DEMUX1TO2_STATS_EN
    logic [15:0]  a_count;
    logic [15:0]  b_count;
`endif

    int checks   = 0;
    int failures = 0;
    int accepted = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic prev_rst = 1'b0;

    always #5 clk = ~clk;

    demux1to2_buffered #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .s         (s),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
`ifdef DEMUX1TO2_STATS_EN
        .b_ready   (b_ready),
        .a_count   (a_count),
        .b_count   (b_count)
`else
        .b_ready   (b_ready)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: inputs are stable from posedge+1 until the next posedge, so at the
    // negedge we know exactly what the coming edge will do.
    always @(negedge clk) begin
        logic exp_rdy;
        if (rst) begin
            chk("rst_din_ready", 32'(din_ready), 32'd0);
            if (prev_rst) begin
                chk("rst_a_valid", 32'(a_valid), 32'd0);
                chk("rst_b_valid", 32'(b_valid), 32'd0);
                chk("rst_a_data", 32'(a_data), 32'd0);
                chk("rst_b_data", 32'(b_data), 32'd0);
            end
            qa.delete();
            qb.delete();
        end else begin
            exp_rdy = s ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
            chk("din_ready", 32'(din_ready), 32'(exp_rdy));
            chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
            chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
            chk("a_data", 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
            chk("b_data", 32'(b_data), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
            if (a_ready && qa.size() != 0) void'(qa.pop_front());
            if (b_ready && qb.size() != 0) void'(qb.pop_front());
            if (din_valid && exp_rdy) begin
                if (s) qa.push_back(din);
                else   qb.push_back(din);
                accepted++;
            end
        end
        prev_rst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [W-1:0] d,
                         input logic ar, input logic br);
        din_valid = v;
        s         = sel;
        din       = d;
        a_ready   = ar;
        b_ready   = br;
        step();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        din_valid = 1'b0;
        a_ready   = 1'b1;
        b_ready   = 1'b1;
        while ((qa.size() != 0 || qb.size() != 0) && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_timeout", 32'(budget < 50), 32'd1);
        step();
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        din_valid = 1'b1;
        s = 1'b1;
        din = 8'hEE;
        a_ready = 1'b0;
        b_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        // Nothing stored after release: valids stay low with no traffic.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Steering, consumers stalled.
        drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Fill a, then verify it blocks only its own channel.
        drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hB1, 1'b0, 1'b0);
        // Full with simultaneous pop: no push this cycle, push the next.
        drive(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        drain();

        // Streaming with random select and random consumer stalls.
        accepted = 0;
        budget = 0;
        while (accepted < 64 && budget < 2000) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            budget++;
        end
        chk("stream_timeout", 32'(budget < 2000), 32'd1);
        drain();

        // Mid-operation reset with both channels occupied.
        drive(1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h32, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux1to2_buffered.md
Name: demux1to2_buffered

Overview:
- Inverse of the team's 2:1 selector. Takes one input word stream tagged by select bit s and steers each word to channel a (s=1) or channel b (s=0).
- Each channel has its own small FIFO with a valid/ready handshake, so the two consumers drain independently.
- Sits downstream of any 2:1 mux stage. Reconstructs the two source streams in per-channel order.

Parameters:
- W, 8, data width in bits (>=1).
- DEPTH, 2, entries per channel FIFO; power of two, >=2.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  W  input word.
- s  in  1  channel select for din: 1 routes to a, 0 routes to b.
- din_valid  in  1  din/s valid this cycle.
- din_ready  out  1  block accepts din this cycle.
- a_data  out  W  head word of channel a.
- a_valid  out  1  channel a FIFO non-empty.
- a_ready  in  1  consumer a takes a_data this cycle.
- b_data  out  W  head word of channel b.
- b_valid  out  1  channel b FIFO non-empty.
- b_ready  in  1  consumer b takes b_data this cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - read/write pointers of both FIFOs cleared.
  - a_valid=b_valid=0 and a_data=b_data=0 from the next cycle.
  - Any buffered words are discarded.
  - Reset wins over a simultaneous push or pop.
- din_ready is combinational: s ? !a_full : !b_full.
  - Depends only on s and the selected FIFO's full flag, never on din_valid.
  - While rst=1, din_ready=0.
- Push: din_valid && din_ready at an edge writes din into the FIFO selected by s. The other FIFO is untouched.
- Pop: a_valid && a_ready at an edge advances channel a's read pointer. Same rule for b.
  - A pop while empty has no effect.
- Latency: a word pushed at edge N appears on the x_data/x_valid outputs after edge N, so a consumer can take it at edge N+1. There is no combinational bypass from din to the outputs.
- x_data is the FIFO head while x_valid=1, and is forced to 0 while x_valid=0.
- Ordering: strict FIFO order within each channel. No ordering relation between channels.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - empty: pointers equal.
  - full: indices equal and MSBs differ.
- Full channel with a simultaneous pop: din_ready is still 0 that cycle, so no push. The freed slot is usable the next cycle.
- Push and pop on the same channel in the same cycle (not full): both occur and the count is unchanged.
- Pushes to one channel and pops from the other proceed concurrently, with no interaction.
- A full channel never stalls the other: with a full and s=0, din_ready=1 if b is not full.
- din_valid=0: no state change from the input side. s is don't-care.

Optional Feature:
- Macro: DEMUX1TO2_STATS_EN.
- When defined, adds outputs a_count and b_count, each 16 bits.
  - A counter increments on every accepted push to its channel.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by rst.
- When undefined, these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - default W and DEPTH.
  - channel-select constants SEL_A=1'b1 and SEL_B=1'b0.
  - stats counter width 16.
- One sub-module, demux_fifo (parameters W, DEPTH; ports clk, rst, push, wdata, pop, rdata, full, empty), instantiated twice.
- The top contains only the steering logic, the ready mux, the output zero-masking and the optional counters.

Test Plan:
- Reset: hold rst for 2 cycles with din_valid=1. Required: a_valid=b_valid=0, a_data=b_data=0, din_ready=0, no words stored after release.
- Steering: push 0x11 (s=1) then 0x22 (s=0), both consumers ready=0. Required: a_data=0x11 and b_data=0x22, each valid one cycle after its push.
- Full: DEPTH=2, a_ready=0, push 0xA1 and 0xA2 with s=1. Required: din_ready=0 while s=1, yet din_ready=1 with s=0, and 0xB1 is accepted to b.
- Full plus pop: a full, a_ready=1, s=1, din_valid=1. Required: that cycle pops 0xA1 with no push; the next cycle accepts; order is preserved as 0xA2 then the new word.
- Streaming: 64 random words with random s and random a_ready/b_ready. Required: each channel's output sequence equals the input subsequence for that s, with no loss or duplication.
- Mid-operation reset: a holds 2 words, b holds 1, assert rst for one edge. Required: both valids 0 next cycle; a fresh push 0x5C with s=0 appears alone on b.
